// File: rtl/matrix_op_defs_pkg.sv
// Shared definitions for the matrix operator bank: storage geometry, shape
// encoding helpers and the result-writer state encoding.
package matrix_op_defs_pkg;

  localparam int MATRIX_DATA_WIDTH = 32;
  localparam int MATRIX_ID_WIDTH   = 3;
  localparam int MATRIX_NUM_SLOTS  = 6;
  localparam int MATRIX_BLOCK_SIZE = 256;
  localparam int MATRIX_ADDR_WIDTH = 11;
  localparam int MATRIX_META_WORDS = 3;

  typedef struct packed {
    logic [7:0] rows;
    logic [7:0] cols;
  } matrix_shape_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    WR_SHAPE = 3'd2,
    WR_NAME0 = 3'd3,
    WR_NAME1 = 3'd4,
    DATA     = 3'd5,
    DONE     = 3'd6
  } matrix_writer_state_e;

  // Slot 0 is the scratch/result slot; operands live in slots 1..NUM_SLOTS-1.
  function automatic logic is_valid_operand_id(input logic [MATRIX_ID_WIDTH-1:0] id);
    return (id != '0) && (id < MATRIX_ID_WIDTH'(MATRIX_NUM_SLOTS));
  endfunction

  function automatic logic [15:0] shape_element_count(input matrix_shape_t shape);
    return 16'(shape.rows) * 16'(shape.cols);
  endfunction

  function automatic logic is_data_capacity_ok(input logic [15:0] count,
                                               input int block_size = MATRIX_BLOCK_SIZE);
    return int'(count) <= (block_size - MATRIX_META_WORDS);
  endfunction

  // Shape word layout: rows in [15:8], cols in [7:0], upper bits zero.
  function automatic matrix_shape_t decode_shape_word(input logic [MATRIX_DATA_WIDTH-1:0] word);
    matrix_shape_t shape;
    shape.rows = word[15:8];
    shape.cols = word[7:0];
    return shape;
  endfunction

  function automatic logic [MATRIX_DATA_WIDTH-1:0] encode_shape_word(input matrix_shape_t shape);
    return {16'h0000, shape.rows, shape.cols};
  endfunction

endpackage

// File: rtl/matrix_address_getter.sv
// Maps a matrix slot id to the base address of its block in matrix storage.
module matrix_address_getter
  import matrix_op_defs_pkg::*;
#(
  parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH
) (
  input  logic [MATRIX_ID_WIDTH-1:0] matrix_id,
  output logic [ADDR_WIDTH-1:0]      base_addr
);

  assign base_addr = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);

endmodule

// File: rtl/matrix_result_writer.sv
// Result sink for matrix operators: validates a write request, writes the
// block metadata words, then streams row-major elements into storage.
module matrix_result_writer
  import matrix_op_defs_pkg::*;
#(
  parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_request,
  output logic                       write_ready,
  input  logic [MATRIX_ID_WIDTH-1:0] matrix_id,
  input  logic [7:0]                 actual_rows,
  input  logic [7:0]                 actual_cols,
  input  logic [7:0]                 matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_valid,
  output logic                       writer_ready,
  output logic                       write_done,
  output logic                       write_error,
  output logic                       mem_wr_en,
  output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
  output logic [DATA_WIDTH-1:0]      mem_wr_data
);

  matrix_writer_state_e        state_reg, state_next;
  logic [MATRIX_ID_WIDTH-1:0]  id_reg;
  matrix_shape_t               shape_reg;
  logic [7:0]                  name_reg [0:7];
  logic [15:0]                 count_reg, count_next;
  logic                        error_reg, error_next;
  logic                        mem_wr_en_reg, mem_wr_en_next;
  logic [ADDR_WIDTH-1:0]       mem_wr_addr_reg, mem_wr_addr_next;
  logic [DATA_WIDTH-1:0]       mem_wr_data_reg, mem_wr_data_next;
  logic                        latch_en;

  logic [ADDR_WIDTH-1:0]       base_addr;
  logic [15:0]                 total_elems;
  logic                        reject;
  logic [31:0]                 name_word0, name_word1;

  matrix_address_getter #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr (
    .matrix_id (id_reg),
    .base_addr (base_addr)
  );

  // Byte 0 of each half lands in the least significant byte of its word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_name_pack
    assign name_word0[gi*8 +: 8] = name_reg[gi];
    assign name_word1[gi*8 +: 8] = name_reg[gi+4];
  end

  assign total_elems = shape_element_count(shape_reg);
  assign reject = (!is_valid_operand_id(id_reg) && (id_reg != '0)) ||
                  (shape_reg.rows == 8'd0) || (shape_reg.cols == 8'd0) ||
                  !is_data_capacity_ok(total_elems, BLOCK_SIZE);

  assign write_ready  = (state_reg == IDLE);
  assign writer_ready = (state_reg == DATA);
  assign write_done   = (state_reg == DONE);
  assign write_error  = error_reg;
  assign mem_wr_en    = mem_wr_en_reg;
  assign mem_wr_addr  = mem_wr_addr_reg;
  assign mem_wr_data  = mem_wr_data_reg;

  // Each metadata write is launched on the edge entering its state so the
  // strobe is visible while the FSM sits in that state.
  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    error_next       = error_reg;
    latch_en         = 1'b0;
    mem_wr_en_next   = 1'b0;
    mem_wr_addr_next = mem_wr_addr_reg;
    mem_wr_data_next = mem_wr_data_reg;
    case (state_reg)
      IDLE: begin
        if (write_request) begin
          latch_en   = 1'b1;
          count_next = '0;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (reject) begin
          error_next = 1'b1;
          state_next = DONE;
        end else begin
          error_next       = 1'b0;
          state_next       = WR_SHAPE;
          mem_wr_en_next   = 1'b1;
          mem_wr_addr_next = base_addr;
          mem_wr_data_next = DATA_WIDTH'(encode_shape_word(shape_reg));
        end
      end
      WR_SHAPE: begin
        state_next       = WR_NAME0;
        mem_wr_en_next   = 1'b1;
        mem_wr_addr_next = base_addr + ADDR_WIDTH'(1);
        mem_wr_data_next = DATA_WIDTH'(name_word0);
      end
      WR_NAME0: begin
        state_next       = WR_NAME1;
        mem_wr_en_next   = 1'b1;
        mem_wr_addr_next = base_addr + ADDR_WIDTH'(2);
        mem_wr_data_next = DATA_WIDTH'(name_word1);
      end
      WR_NAME1: begin
        state_next = DATA;
      end
      DATA: begin
        if (data_valid) begin
          mem_wr_en_next   = 1'b1;
          mem_wr_addr_next = base_addr + ADDR_WIDTH'(MATRIX_META_WORDS) + ADDR_WIDTH'(count_reg);
          mem_wr_data_next = data_in;
          count_next       = count_reg + 16'd1;
          if (count_next == total_elems) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      id_reg          <= '0;
      shape_reg       <= '0;
      count_reg       <= '0;
      error_reg       <= 1'b0;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_addr_reg <= '0;
      mem_wr_data_reg <= '0;
      for (int i = 0; i < 8; i++) begin
        name_reg[i] <= '0;
      end
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      error_reg       <= error_next;
      mem_wr_en_reg   <= mem_wr_en_next;
      mem_wr_addr_reg <= mem_wr_addr_next;
      mem_wr_data_reg <= mem_wr_data_next;
      if (latch_en) begin
        id_reg         <= matrix_id;
        shape_reg.rows <= actual_rows;
        shape_reg.cols <= actual_cols;
        for (int i = 0; i < 8; i++) begin
          name_reg[i] <= matrix_name[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_writer.sv
// Self-checking bench for matrix_result_writer: a scoreboard of expected
// storage writes is filled as stimulus is driven and drained by a monitor.
module tb_matrix_result_writer;

  logic        clk;
  logic        rst;
  logic        write_request;
  logic        write_ready;
  logic [2:0]  matrix_id;
  logic [7:0]  actual_rows;
  logic [7:0]  actual_cols;
  logic [7:0]  matrix_name [0:7];
  logic [31:0] data_in;
  logic        data_valid;
  logic        writer_ready;
  logic        write_done;
  logic        write_error;
  logic        mem_wr_en;
  logic [10:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  typedef struct {
    logic [10:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mem_model [0:2047];
  logic [10:0] cur_base;
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          wr_cnt    = 0;
  int          done_cnt  = 0;
  int          beef_cnt  = 0;

  matrix_result_writer dut (
    .clk           (clk),
    .rst           (rst),
    .write_request (write_request),
    .write_ready   (write_ready),
    .matrix_id     (matrix_id),
    .actual_rows   (actual_rows),
    .actual_cols   (actual_cols),
    .matrix_name   (matrix_name),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .writer_ready  (writer_ready),
    .write_done    (write_done),
    .write_error   (write_error),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every storage write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      exp_t e;
      wr_cnt++;
      mem_model[mem_wr_addr] = mem_wr_data;
      if (mem_wr_data === 32'hDEADBEEF) beef_cnt++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", mem_wr_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_wr_addr !== e.addr || mem_wr_data !== e.data)
          $display("FAIL mem_write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   mem_wr_addr, mem_wr_data, e.addr, e.data);
        else
          pass_cnt++;
      end
    end
    if (write_done === 1'b1) done_cnt++;
  end

  function automatic logic model_accept(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c);
    logic [15:0] tot;
    tot = 16'(r) * 16'(c);
    return (id <= 3'd5) && (r != 8'd0) && (c != 8'd0) && (tot <= 16'd253);
  endfunction

  // Drives a one-cycle request from a negedge with the DUT idle; returns one
  // negedge later (DUT in CHECK) with the request fields scrambled.
  task automatic send_request(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                              input logic [63:0] nm);
    logic [7:0] b [0:7];
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      b[k] = nm[63-8*k -: 8];
      matrix_name[k] = b[k];
    end
    matrix_id     = id;
    actual_rows   = r;
    actual_cols   = c;
    write_request = 1'b1;
    cur_base      = 11'(id) * 11'd256;
    if (model_accept(id, r, c)) begin
      e.addr = cur_base;          e.data = {16'h0000, r, c};          exp_q.push_back(e);
      e.addr = cur_base + 11'd1;  e.data = {b[3], b[2], b[1], b[0]};  exp_q.push_back(e);
      e.addr = cur_base + 11'd2;  e.data = {b[7], b[6], b[5], b[4]};  exp_q.push_back(e);
    end
    @(negedge clk);
    write_request = 1'b0;
    matrix_id     = 3'($urandom);
    actual_rows   = 8'($urandom);
    actual_cols   = 8'($urandom);
    for (int k = 0; k < 8; k++) matrix_name[k] = 8'($urandom);
    $display("txn request id=%0d rows=%0d cols=%0d name=%s", id, r, c, nm);
  endtask

  task automatic push_beat(input int idx, input logic [31:0] v);
    exp_t e;
    e.addr = cur_base + 11'd3 + 11'(idx);
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++; if (write_ready !== 1'b1) $display("FAIL reset_write_ready: got %b, required 1", write_ready); else pass_cnt++;
    check_cnt++; if (writer_ready !== 1'b0) $display("FAIL reset_writer_ready: got %b, required 0", writer_ready); else pass_cnt++;
    check_cnt++; if (write_done !== 1'b0) $display("FAIL reset_write_done: got %b, required 0", write_done); else pass_cnt++;
    check_cnt++; if (write_error !== 1'b0) $display("FAIL reset_write_error: got %b, required 0", write_error); else pass_cnt++;
    check_cnt++; if (mem_wr_en !== 1'b0) $display("FAIL reset_mem_wr_en: got %b, required 0", mem_wr_en); else pass_cnt++;
    check_cnt++; if (mem_wr_addr !== 11'd0 || mem_wr_data !== 32'd0)
      $display("FAIL reset_mem_bus: got addr=%0h data=%08h, required 0/0", mem_wr_addr, mem_wr_data); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] nm = "TRANSPOS";
    int d0 = done_cnt;
    int w0 = wr_cnt;
    send_request(3'd0, 8'd2, 8'd3, nm);
    check_cnt++; if (write_ready !== 1'b0) $display("FAIL b2b_busy: got write_ready=%b, required 0", write_ready); else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++; if (writer_ready !== 1'b0) $display("FAIL b2b_ready_early: got writer_ready=%b, required 0", writer_ready); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (writer_ready !== 1'b1) $display("FAIL b2b_ready_t5: got writer_ready=%b, required 1", writer_ready); else pass_cnt++;
    for (int i = 1; i <= 6; i++) begin
      data_in    = 32'(i);
      data_valid = 1'b1;
      push_beat(i - 1, 32'(i));
      @(negedge clk);
    end
    data_valid = 1'b0;
    check_cnt++; if (write_done !== 1'b1 || write_error !== 1'b0)
      $display("FAIL b2b_done: got done=%b error=%b, required 1/0", write_done, write_error); else pass_cnt++;
    check_cnt++; if (writer_ready !== 1'b0) $display("FAIL b2b_no_extra_beat: got writer_ready=%b, required 0", writer_ready); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (write_ready !== 1'b1 || write_done !== 1'b0)
      $display("FAIL b2b_idle: got write_ready=%b done=%b, required 1/0", write_ready, write_done); else pass_cnt++;
    check_cnt++; if (done_cnt != d0 + 1 || wr_cnt != w0 + 9)
      $display("FAIL b2b_counts: got done=%0d writes=%0d, required 1/9", done_cnt - d0, wr_cnt - w0); else pass_cnt++;
  endtask

  task automatic test_gapped_valid();
    logic [63:0] nm = "TRANSPOS";
    logic [31:0] img [0:8];
    int d0 = done_cnt;
    img[0] = 32'h00000203;
    img[1] = 32'h4E415254;
    img[2] = 32'h534F5053;
    for (int k = 3; k < 9; k++) img[k] = 32'(k - 2);
    for (int k = 0; k < 9; k++) mem_model[k] = 32'hX;
    send_request(3'd0, 8'd2, 8'd3, nm);
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      data_in    = 32'(i);
      data_valid = 1'b1;
      push_beat(i - 1, 32'(i));
      @(negedge clk);
      data_valid = 1'b0;
      data_in    = 32'hDEADBEEF;
      if (i < 6) begin
        @(negedge clk);
        if (i == 5) begin
          check_cnt++; if (write_done !== 1'b0 || writer_ready !== 1'b1)
            $display("FAIL gap_hold: got done=%b writer_ready=%b, required 0/1", write_done, writer_ready); else pass_cnt++;
        end
      end
    end
    check_cnt++; if (write_done !== 1'b1) $display("FAIL gap_done: got %b, required 1", write_done); else pass_cnt++;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      check_cnt++;
      if (mem_model[k] !== img[k]) $display("FAIL gap_image[%0d]: got %08h, required %08h", k, mem_model[k], img[k]);
      else pass_cnt++;
    end
    check_cnt++; if (done_cnt != d0 + 1) $display("FAIL gap_done_count: got %0d, required 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_reject();
    logic [2:0] t_id   [5] = '{3'd1, 3'd2, 3'd6, 3'd3, 3'd4};
    logic [7:0] t_rows [5] = '{8'd0, 8'd255, 8'd2, 8'd4, 8'd2};
    logic [7:0] t_cols [5] = '{8'd3, 8'd255, 8'd3, 8'd0, 8'd127};
    for (int n = 0; n < 5; n++) begin
      int d0 = done_cnt;
      int w0 = wr_cnt;
      send_request(t_id[n], t_rows[n], t_cols[n], "REJECTED");
      check_cnt++; if (write_done !== 1'b0) $display("FAIL rej%0d_early_done: got %b, required 0", n, write_done); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (write_done !== 1'b1 || write_error !== 1'b1)
        $display("FAIL rej%0d_t2: got done=%b error=%b, required 1/1", n, write_done, write_error); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (write_ready !== 1'b1 || write_done !== 1'b0)
        $display("FAIL rej%0d_idle: got write_ready=%b done=%b, required 1/0", n, write_ready, write_done); else pass_cnt++;
      check_cnt++; if (wr_cnt != w0 || done_cnt != d0 + 1)
        $display("FAIL rej%0d_counts: got writes=%0d done=%0d, required 0/1", n, wr_cnt - w0, done_cnt - d0); else pass_cnt++;
    end
  endtask

  task automatic test_capacity_boundary();
    int d0 = done_cnt;
    logic [31:0] v;
    send_request(3'd5, 8'd11, 8'd23, "FULLBLK!");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 253; i++) begin
      v          = $urandom;
      data_in    = v;
      data_valid = 1'b1;
      push_beat(i, v);
      @(negedge clk);
    end
    data_valid = 1'b0;
    check_cnt++; if (write_done !== 1'b1 || write_error !== 1'b0)
      $display("FAIL cap_done: got done=%b error=%b, required 1/0", write_done, write_error); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (done_cnt != d0 + 1 || exp_q.size() != 0)
      $display("FAIL cap_drain: got done=%0d pending=%0d, required 1/0", done_cnt - d0, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    int d0 = done_cnt;
    send_request(3'd3, 8'd4, 8'd4, "PARTIAL4");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      data_in    = 32'h100 + 32'(i);
      data_valid = 1'b1;
      push_beat(i, 32'h100 + 32'(i));
      @(negedge clk);
    end
    data_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check_cnt++; if (write_ready !== 1'b1 || writer_ready !== 1'b0)
      $display("FAIL rstmid_idle: got write_ready=%b writer_ready=%b, required 1/0", write_ready, writer_ready); else pass_cnt++;
    check_cnt++; if (write_done !== 1'b0 || mem_wr_en !== 1'b0)
      $display("FAIL rstmid_quiet: got done=%b wr_en=%b, required 0/0", write_done, mem_wr_en); else pass_cnt++;
    rst = 1'b0;
    send_request(3'd4, 8'd1, 8'd1, "RESULT01");
    check_cnt++; if (done_cnt != d0) $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_cnt - d0); else pass_cnt++;
    repeat (4) @(negedge clk);
    data_in    = 32'h55;
    data_valid = 1'b1;
    push_beat(0, 32'h55);
    @(negedge clk);
    data_valid = 1'b0;
    check_cnt++; if (write_done !== 1'b1 || write_error !== 1'b0)
      $display("FAIL rstmid_fresh_done: got done=%b error=%b, required 1/0", write_done, write_error); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (exp_q.size() != 0) $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_spurious_valid();
    int w0 = wr_cnt;
    data_in    = 32'hDEADBEEF;
    data_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if (wr_cnt != w0 || write_ready !== 1'b1)
      $display("FAIL idle_valid: got writes=%0d write_ready=%b, required 0/1", wr_cnt - w0, write_ready); else pass_cnt++;
    data_valid = 1'b0;
    send_request(3'd2, 8'd1, 8'd2, "SPURIOUS");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      data_in    = 32'hA0 + 32'(i);
      data_valid = 1'b1;
      push_beat(i, 32'hA0 + 32'(i));
      @(negedge clk);
    end
    data_in = 32'hDEADBEEF;
    check_cnt++; if (write_done !== 1'b1) $display("FAIL spur_done: got %b, required 1", write_done); else pass_cnt++;
    repeat (3) @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    check_cnt++; if (wr_cnt != w0 + 5 || beef_cnt != 0 || exp_q.size() != 0)
      $display("FAIL spur_writes: got writes=%0d beef=%0d pending=%0d, required 5/0/0",
               wr_cnt - w0, beef_cnt, exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    rst           = 1'b1;
    write_request = 1'b0;
    matrix_id     = '0;
    actual_rows   = '0;
    actual_cols   = '0;
    data_in       = '0;
    data_valid    = 1'b0;
    for (int k = 0; k < 8; k++) matrix_name[k] = '0;
    test_reset();
    test_back_to_back();
    test_gapped_valid();
    test_reject();
    test_capacity_boundary();
    test_reset_mid_write();
    test_spurious_valid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
